// File: rtl/msg_queue_narrow.sv
// msg_queue_narrow
//   Buffer that sits after the 3-way narrow message joiner. It stores
//   {source tag, message} pairs in a small FIFO and presents the oldest one
//   to the next consumer. The all-ones message value means "no message" on
//   both the input and the output. It also reports the current occupancy and
//   a resettable high-water mark.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   msgin        message offered by the joiner (all ones = nothing offered)
//   msgin_src    joiner source tag, stored exactly as given
//   msgin_ack    accept strobe back to the joiner (combinational)
//   msgout       head message (all ones when the queue is empty)
//   msgout_src   source tag of the head entry (0 when the queue is empty)
//   msgout_ack   downstream consumes the head entry this cycle
//   count        current occupancy, 0..DEPTH
//   hiwater      highest occupancy seen since reset or the last clear
//   hiwater_clr  synchronous clear: hiwater is loaded with the next count
module msg_queue_narrow #(
  parameter int WBUFS = 6,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WBUFS-1:0] msgin,
  input  logic [1:0]       msgin_src,
  output logic             msgin_ack,
  output logic [WBUFS-1:0] msgout,
  output logic [1:0]       msgout_src,
  input  logic             msgout_ack,
  output logic [AW:0]      count,
  output logic [AW:0]      hiwater,
  input  logic             hiwater_clr
);

  localparam int               DEPTH    = 1 << AW;
  localparam logic [AW:0]      FULL_CNT = DEPTH[AW:0];
  localparam logic [WBUFS-1:0] NOTLEGAL = '1;

  logic [WBUFS+1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      next_count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Full and empty come from the registered count, never from comparing the
  // pointers. That keeps msgin_ack free of any path from msgout_ack: a full
  // queue refuses input even in a cycle where the head is being consumed.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Gating with rst keeps the ack low, and the memory from being written,
  // for as long as reset is held.
  assign push = (msgin != NOTLEGAL) && !full && !rst;
  assign pop  = !empty && msgout_ack;

  assign msgin_ack = push;

  // The head is read straight from storage. A new entry only shows up here
  // after the edge that writes it, so an empty queue never flows through.
  always_comb begin
    msgout     = NOTLEGAL;
    msgout_src = 2'd0;
    if (!empty) begin
      {msgout_src, msgout} = mem[rptr];
    end
  end

  always_comb begin
    next_count = count;
    if (push && !pop) begin
      next_count = count + 1'b1;
    end else if (pop && !push) begin
      next_count = count - 1'b1;
    end
  end

  // Storage has no reset. After reset, entries are invisible because the
  // count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {msgin_src, msgin};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      hiwater <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= next_count;
      // A clear has priority and loads the next count rather than zero, so
      // the mark is immediately consistent with what is actually queued.
      if (hiwater_clr || (next_count > hiwater)) begin
        hiwater <= next_count;
      end
    end
  end

endmodule

// File: tb/tb_msg_queue_narrow.sv
module tb_msg_queue_narrow;

  logic       clk;
  logic       rst;
  logic [5:0] msgin;
  logic [1:0] msgin_src;
  logic       msgin_ack;
  logic [5:0] msgout;
  logic [1:0] msgout_src;
  logic       msgout_ack;
  logic [2:0] count;
  logic [2:0] hiwater;
  logic       hiwater_clr;

  int vectors;
  int errors;

  msg_queue_narrow #(.WBUFS(6), .AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .msgin(msgin),
    .msgin_src(msgin_src),
    .msgin_ack(msgin_ack),
    .msgout(msgout),
    .msgout_src(msgout_src),
    .msgout_ack(msgout_ack),
    .count(count),
    .hiwater(hiwater),
    .hiwater_clr(hiwater_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge. Outputs are sampled 1 ns later,
  // well away from the rising edge.
  task automatic test_reset();
    rst = 1'b1; msgin = 6'h3F; msgin_src = 2'd0; msgout_ack = 1'b0; hiwater_clr = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({msgin_ack, msgout, msgout_src, count, hiwater} !== {1'b0, 6'h3F, 2'd0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: ack/out/src/count/hw = %b/%h/%0d/%0d/%0d, want 0/3f/0/0/0",
               msgin_ack, msgout, msgout_src, count, hiwater);
    end
    @(negedge clk);
    rst = 1'b0;
    // Idle for 10 cycles; msgout_ack while empty must be ignored.
    for (int i = 0; i < 10; i++) begin
      msgout_ack = i[0];
      #1;
      vectors++;
      if ({msgin_ack, msgout, msgout_src, count} !== {1'b0, 6'h3F, 2'd0, 3'd0}) begin
        errors++;
        $display("FAIL idle_cycle%0d: ack/out/src/count = %b/%h/%0d/%0d, want 0/3f/0/0",
                 i, msgin_ack, msgout, msgout_src, count);
      end
      @(negedge clk);
    end
    msgout_ack = 1'b0;
  endtask

  task automatic test_single();
    msgin = 6'h05; msgin_src = 2'd2; msgout_ack = 1'b0;
    #1;
    vectors++;
    if ({msgin_ack, msgout, count} !== {1'b1, 6'h3F, 3'd0}) begin
      errors++;
      $display("FAIL single_push: ack/out/count = %b/%h/%0d, want 1/3f/0", msgin_ack, msgout, count);
    end
    @(negedge clk);
    msgin = 6'h3F; msgin_src = 2'd0;
    #1;
    vectors++;
    if ({msgin_ack, msgout, msgout_src, count} !== {1'b0, 6'h05, 2'd2, 3'd1}) begin
      errors++;
      $display("FAIL single_visible: ack/out/src/count = %b/%h/%0d/%0d, want 0/05/2/1",
               msgin_ack, msgout, msgout_src, count);
    end
    msgout_ack = 1'b1;
    @(negedge clk);
    msgout_ack = 1'b0;
    #1;
    vectors++;
    if ({msgout, msgout_src, count} !== {6'h3F, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL single_pop: out/src/count = %h/%0d/%0d, want 3f/0/0", msgout, msgout_src, count);
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [1:0] tags [4];
    logic [5:0] exp_msg [5];
    logic [1:0] exp_src [5];
    logic [2:0] exp_cnt [5];
    tags[0] = 2'd1; tags[1] = 2'd2; tags[2] = 2'd3; tags[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      msgin = 6'(i + 1); msgin_src = tags[i];
      #1;
      vectors++;
      if (msgin_ack !== 1'b1) begin
        errors++;
        $display("FAIL fill_ack%0d: msgin_ack = %b, want 1", i, msgin_ack);
      end
      @(negedge clk);
    end
    msgin = 6'h09; msgin_src = 2'd2;
    #1;
    vectors++;
    if ({msgin_ack, count, hiwater} !== {1'b0, 3'd4, 3'd4}) begin
      errors++;
      $display("FAIL fill_full: ack/count/hw = %b/%0d/%0d, want 0/4/4", msgin_ack, count, hiwater);
    end
    // Drain while 0x09 is still offered; it goes in the cycle after the first pop.
    exp_msg[0] = 6'h01; exp_msg[1] = 6'h02; exp_msg[2] = 6'h03; exp_msg[3] = 6'h04; exp_msg[4] = 6'h09;
    exp_src[0] = 2'd1;  exp_src[1] = 2'd2;  exp_src[2] = 2'd3;  exp_src[3] = 2'd1;  exp_src[4] = 2'd2;
    exp_cnt[0] = 3'd4;  exp_cnt[1] = 3'd3;  exp_cnt[2] = 3'd3;  exp_cnt[3] = 3'd2;  exp_cnt[4] = 3'd1;
    msgout_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({msgout, msgout_src, count} !== {exp_msg[i], exp_src[i], exp_cnt[i]}) begin
        errors++;
        $display("FAIL drain%0d: out/src/count = %h/%0d/%0d, want %h/%0d/%0d",
                 i, msgout, msgout_src, count, exp_msg[i], exp_src[i], exp_cnt[i]);
      end
      if (i < 2) begin
        vectors++;
        if (msgin_ack !== (i == 1)) begin
          errors++;
          $display("FAIL drain_ack%0d: msgin_ack = %b, want %b", i, msgin_ack, (i == 1));
        end
      end
      @(negedge clk);
      if (i == 1) begin
        msgin = 6'h3F; msgin_src = 2'd0;
      end
    end
    msgout_ack = 1'b0;
    #1;
    vectors++;
    if ({msgout, count, hiwater} !== {6'h3F, 3'd0, 3'd4}) begin
      errors++;
      $display("FAIL drain_empty: out/count/hw = %h/%0d/%0d, want 3f/0/4", msgout, count, hiwater);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) begin
        msgin = 6'(k + 10); msgin_src = 2'(k % 3 + 1);
      end else begin
        msgin = 6'h3F; msgin_src = 2'd0;
      end
      msgout_ack = (k > 0);
      #1;
      if (k > 0) begin
        vectors++;
        if ({msgout, msgout_src, count} !== {6'(k + 9), 2'((k - 1) % 3 + 1), 3'd1}) begin
          errors++;
          $display("FAIL stream%0d: out/src/count = %h/%0d/%0d, want %h/%0d/1",
                   k, msgout, msgout_src, count, 6'(k + 9), (k - 1) % 3 + 1);
        end
      end
      if (k < 20) begin
        vectors++;
        if (msgin_ack !== 1'b1) begin
          errors++;
          $display("FAIL stream_ack%0d: msgin_ack = %b, want 1", k, msgin_ack);
        end
      end
      @(negedge clk);
    end
    msgout_ack = 1'b0;
    #1;
    vectors++;
    if ({msgout, count} !== {6'h3F, 3'd0}) begin
      errors++;
      $display("FAIL stream_end: out/count = %h/%0d, want 3f/0", msgout, count);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      msgin = 6'(8'h11 + i); msgin_src = 2'(i + 1);
      @(negedge clk);
    end
    msgin = 6'h3F; msgin_src = 2'd0;
    #1;
    vectors++;
    if ({msgout, count} !== {6'h11, 3'd3}) begin
      errors++;
      $display("FAIL pre_reset: out/count = %h/%0d, want 11/3", msgout, count);
    end
    #1;
    rst = 1'b1; msgin = 6'h15; msgin_src = 2'd1;
    #1;
    vectors++;
    if ({msgin_ack, msgout, msgout_src, count, hiwater} !== {1'b0, 6'h3F, 2'd0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL async_reset: ack/out/src/count/hw = %b/%h/%0d/%0d/%0d, want 0/3f/0/0/0",
               msgin_ack, msgout, msgout_src, count, hiwater);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; msgin = 6'h3F; msgin_src = 2'd0; msgout_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({msgout, count} !== {6'h3F, 3'd0}) begin
        errors++;
        $display("FAIL post_reset%0d: out/count = %h/%0d, want 3f/0", i, msgout, count);
      end
      @(negedge clk);
    end
    msgout_ack = 1'b0; msgin = 6'h22; msgin_src = 2'd3;
    @(negedge clk);
    msgin = 6'h3F; msgin_src = 2'd0;
    #1;
    vectors++;
    if ({msgout, msgout_src, count} !== {6'h22, 2'd3, 3'd1}) begin
      errors++;
      $display("FAIL post_reset_push: out/src/count = %h/%0d/%0d, want 22/3/1", msgout, msgout_src, count);
    end
    msgout_ack = 1'b1;
    @(negedge clk);
    msgout_ack = 1'b0;
  endtask

  task automatic test_hiwater_clr();
    for (int i = 0; i < 4; i++) begin
      msgin = 6'(8'h31 + i); msgin_src = 2'(i % 3 + 1);
      @(negedge clk);
    end
    msgin = 6'h3F; msgin_src = 2'd0;
    #1;
    vectors++;
    if ({count, hiwater} !== {3'd4, 3'd4}) begin
      errors++;
      $display("FAIL hw_peak: count/hw = %0d/%0d, want 4/4", count, hiwater);
    end
    msgout_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    msgout_ack = 1'b0; hiwater_clr = 1'b1;
    #1;
    vectors++;
    if ({count, hiwater} !== {3'd2, 3'd4}) begin
      errors++;
      $display("FAIL hw_before_clr: count/hw = %0d/%0d, want 2/4", count, hiwater);
    end
    @(negedge clk);
    hiwater_clr = 1'b0; msgin = 6'h35; msgin_src = 2'd2;
    #1;
    vectors++;
    if ({count, hiwater} !== {3'd2, 3'd2}) begin
      errors++;
      $display("FAIL hw_cleared: count/hw = %0d/%0d, want 2/2", count, hiwater);
    end
    @(negedge clk);
    msgin = 6'h3F; msgin_src = 2'd0;
    #1;
    vectors++;
    if ({count, hiwater, msgout, msgout_src} !== {3'd3, 3'd3, 6'h33, 2'd3}) begin
      errors++;
      $display("FAIL hw_rise: count/hw/out/src = %0d/%0d/%h/%0d, want 3/3/33/3",
               count, hiwater, msgout, msgout_src);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_async_reset();
    test_hiwater_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/msg_queue_narrow.md
Name: msg_queue_narrow

Overview:
- Buffering stage directly downstream of the 3-way narrow message joiner.
- Consumes the joiner's merged message and its 2-bit source tag, and drives the joiner's output-ack.
- Stores message+source pairs in a small FIFO and presents them to the next consumer with the same "all-ones = no message" convention.
- Decouples joiner arbitration from consumer stalls and reports occupancy and a high-water mark.

Parameters:
- WBUFS, 6, message width in bits; the all-ones value (NOTLEGAL = 2^WBUFS-1) means "no message".
- AW, 2, address width; DEPTH = 2^AW entries (legal AW 1..5).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- msgin  input  WBUFS  message from joiner; NOTLEGAL = nothing offered.
- msgin_src  input  2  joiner source tag (1..3; 0 only when msgin==NOTLEGAL).
- msgin_ack  output  1  accept strobe back to the joiner's output-ack.
- msgout  output  WBUFS  head message; NOTLEGAL when queue empty.
- msgout_src  output  2  source tag of head entry; 0 when empty.
- msgout_ack  input  1  downstream consumes head this cycle.
- count  output  AW+1  current occupancy 0..DEPTH.
- hiwater  output  AW+1  max occupancy since reset or clear.
- hiwater_clr  input  1  synchronous clear of hiwater to current count.

Behaviour:
- Reset (async, rst=1):
  - wptr=0, rptr=0, count=0, hiwater=0.
  - msgout=NOTLEGAL, msgout_src=0, msgin_ack=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued entries immediately; outputs go to reset values in the same cycle rst rises.
- Definitions:
  - full = (count==DEPTH); empty = (count==0).
  - push = (msgin!=NOTLEGAL) && !full.
  - pop = !empty && msgout_ack.
- msgin_ack = push, combinational.
  - Depends only on msgin and registered full.
  - No dependence on msgout_ack, so there is no combinational path from msgout_ack to msgin_ack (no bypass when full).
- Push:
  - On a clock edge with push=1: mem[wptr] <= {msgin_src, msgin}; wptr <= wptr+1, wrapping modulo DEPTH.
  - msgin_src is stored as given; a push with tag 0 is stored unchanged, with no checking.
- Pop:
  - msgout/msgout_src are driven combinationally from mem[rptr] when !empty, else NOTLEGAL/0.
  - On a clock edge with pop=1: rptr <= rptr+1, wrapping.
  - msgout_ack while empty is ignored: no pointer change, no error.
- Latency: an entry pushed at edge N is visible on msgout after edge N (first-word latency 1 cycle). There is no flow-through when empty.
- Count:
  - push&!pop: +1. pop&!push: -1. Both or neither: unchanged.
  - Never exceeds DEPTH and never goes below 0, by construction.
- Full with simultaneous pop: msgin_ack stays 0 that cycle; the freed slot is usable the next cycle.
- Empty with push: msgout stays NOTLEGAL that cycle.
- High-water mark:
  - Normally each edge: hiwater <= max(hiwater, next_count).
  - When hiwater_clr=1: hiwater <= next_count, which takes priority.
- Order: strict FIFO. Source tag always travels with its message.
- Wrap-around: pointers are AW bits and wrap naturally. Full/empty come from count, not from pointer compare.

Test Plan:
- Reset then idle (msgin=6'h3F) -> msgin_ack=0, msgout=6'h3F, msgout_src=0, count=0 for 10 cycles.
- Single message: msgin=6'h05, src=2 for one cycle, msgout_ack=0 -> msgin_ack=1 that cycle; next cycle msgout=6'h05, src=2, count=1. Assert msgout_ack -> next cycle msgout=6'h3F, count=0.
- Fill with msgout_ack=0: push 0x01..0x04 (src 1,2,3,1), then offer 0x09 -> acks on 4 cycles then msgin_ack=0 with count=4, hiwater=4. Drain in order 0x01,0x02,0x03,0x04 with correct tags; 0x09 is accepted the cycle after the first pop.
- Continuous stream: push every cycle and pop every cycle for 20 messages -> count holds at 1. Outputs in order, pointers wrap 5 times, no loss or duplication.
- Async reset with count=3 mid-stream -> msgout=6'h3F, count=0, hiwater=0 immediately. After release, old entries never appear.
- hiwater_clr pulse at count=2 after peak 4 -> hiwater=2 next cycle. Then rises again with further pushes.
